// File: rtl/display_scanner.sv
// display_scanner
//   Time-multiplexes an 8-entry x 6-bit digit memory onto an 8-digit
//   common-anode seven-segment display.  Writes go to a shadow buffer
//   that is copied to the displayed buffer only when the scan wraps
//   from digit 0 back to digit 7, so a multi-digit update never tears.
//
// Ports
//   clk   : system clock, rising edge
//   rst   : asynchronous active-high reset
//   W     : write strobe (active-high)
//   WADD  : digit address 0..7
//   DIN   : {enable, hex[3:0], dp_dark}
//   AN    : anode drives, active-low, AN[i] = digit i
//   SEG   : {g,f,e,d,c,b,a}, active-low
//   DP    : decimal point, active-low
//   FRAME : one-cycle pulse after the scan wraps 0 -> 7
module display_scanner #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 2000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       W,
    input  logic [2:0] WADD,
    input  logic [5:0] DIN,
    output logic [7:0] AN,
    output logic [6:0] SEG,
    output logic       DP,
    output logic       FRAME
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);

    typedef enum logic {
        BLANK,
        SHOW
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [5:0]    shadow [8];
    logic [5:0]    active [8];
    logic          dirty;

    logic          slot_end;
    logic          wrap;
    logic [5:0]    d;
    logic          lit;
    logic [7:0]    an_nxt;
    logic [6:0]    seg_nxt;
    logic          dp_nxt;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0:    hex7 = 7'h40;
            4'h1:    hex7 = 7'h79;
            4'h2:    hex7 = 7'h24;
            4'h3:    hex7 = 7'h30;
            4'h4:    hex7 = 7'h19;
            4'h5:    hex7 = 7'h12;
            4'h6:    hex7 = 7'h02;
            4'h7:    hex7 = 7'h78;
            4'h8:    hex7 = 7'h00;
            4'h9:    hex7 = 7'h10;
            4'hA:    hex7 = 7'h08;
            4'hB:    hex7 = 7'h03;
            4'hC:    hex7 = 7'h46;
            4'hD:    hex7 = 7'h21;
            4'hE:    hex7 = 7'h06;
            default: hex7 = 7'h0E;
        endcase
    endfunction

    assign slot_end = (cnt == CNT_LAST);
    assign wrap     = slot_end && (idx == 3'd0);

    // The state register is updated from the *next* cnt value so that
    // state always matches the current cnt; the output stage then adds
    // exactly one cycle of latency.
    always_comb begin
        state_nxt = state;
        if (slot_end) begin
            state_nxt = (BLANK_CYCLES == 0) ? SHOW : BLANK;
        end else if (cnt + 1'b1 == BLANK_END) begin
            state_nxt = SHOW;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= BLANK;
            cnt   <= '0;
            idx   <= 3'd7;
        end else begin
            state <= state_nxt;
            if (slot_end) begin
                cnt <= '0;
                idx <= idx - 3'd1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Commit reads the pre-write shadow; a coincident write keeps dirty set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < 8; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
            dirty <= 1'b0;
        end else begin
            if (wrap && dirty) begin
                for (int unsigned i = 0; i < 8; i++) begin
                    active[i] <= shadow[i];
                end
            end
            if (W) begin
                shadow[WADD] <= DIN;
                dirty        <= 1'b1;
            end else if (wrap) begin
                dirty <= 1'b0;
            end
        end
    end

    always_comb begin
        d       = active[idx];
        lit     = (state == SHOW) && d[5];
        an_nxt  = 8'hFF;
        seg_nxt = 7'h7F;
        dp_nxt  = 1'b1;
        if (lit) begin
            an_nxt  = ~(8'b1 << idx);
            seg_nxt = hex7(d[4:1]);
            dp_nxt  = d[0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            AN    <= '1;
            SEG   <= '1;
            DP    <= 1'b1;
            FRAME <= 1'b0;
        end else begin
            AN    <= an_nxt;
            SEG   <= seg_nxt;
            DP    <= dp_nxt;
            FRAME <= wrap;
        end
    end

endmodule

// File: tb/tb_display_scanner.sv
module tb_display_scanner;

    localparam int RD = 8;
    localparam int BC = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       W;
    logic [2:0] WADD;
    logic [5:0] DIN;
    logic [7:0] AN;
    logic [6:0] SEG;
    logic       DP;
    logic       FRAME;

    int total = 0;
    int bad   = 0;
    logic armed = 1'b0;

    display_scanner #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
        .clk(clk), .rst(rst), .W(W), .WADD(WADD), .DIN(DIN),
        .AN(AN), .SEG(SEG), .DP(DP), .FRAME(FRAME)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // Position in the scan is derived from elapsed cycles since reset:
    // slot number = t / RD (mod 8) gives digit 7 - slot, t % RD is the
    // offset inside the slot.
    logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    int unsigned tcount;
    logic [5:0]  m_sh  [8];
    logic [5:0]  m_act [8];
    logic        m_dirty;
    logic [7:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp;
    logic        e_frame;

    function automatic int unsigned f_pos(input int unsigned t);
        return t % RD;
    endfunction

    function automatic int unsigned f_dig(input int unsigned t);
        return 7 - ((t / RD) % 8);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            tcount  <= 0;
            m_dirty <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                m_sh[i]  <= '0;
                m_act[i] <= '0;
            end
            e_an    <= 8'hFF;
            e_seg   <= 7'h7F;
            e_dp    <= 1'b1;
            e_frame <= 1'b0;
        end else begin
            if (f_pos(tcount) >= BC && m_act[f_dig(tcount)][5]) begin
                e_an  <= ~(8'b1 << f_dig(tcount));
                e_seg <= hex_tab[m_act[f_dig(tcount)][4:1]];
                e_dp  <= m_act[f_dig(tcount)][0];
            end else begin
                e_an  <= 8'hFF;
                e_seg <= 7'h7F;
                e_dp  <= 1'b1;
            end
            e_frame <= (f_pos(tcount) == RD - 1) && (f_dig(tcount) == 0);
            if ((f_pos(tcount) == RD - 1) && (f_dig(tcount) == 0)) begin
                if (m_dirty) begin
                    for (int i = 0; i < 8; i++) m_act[i] <= m_sh[i];
                end
                m_dirty <= 1'b0;
            end
            if (W) begin
                m_sh[WADD] <= DIN;
                m_dirty    <= 1'b1;
            end
            tcount <= tcount + 1;
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (armed) begin
            chk("model_AN", AN, e_an);
            chk("model_SEG", {1'b0, SEG}, {1'b0, e_seg});
            chk("model_DP", {7'b0, DP}, {7'b0, e_dp});
            chk("model_FRAME", {7'b0, FRAME}, {7'b0, e_frame});
            chk("an_at_most_one_low", {7'b0, ($countones(~AN) > 1)}, 8'h00);
        end
    end

    task automatic skip(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_frame();
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (FRAME !== 1'b1 && k < 200);
        chk("frame_timeout", {7'b0, FRAME}, 8'h01);
    endtask

    task automatic wr(input logic [2:0] a, input logic [5:0] v);
        @(negedge clk);
        W = 1'b1; WADD = a; DIN = v;
        @(negedge clk);
        W = 1'b0;
    endtask

    task automatic chk_disp(input string nm, input logic [7:0] an, input logic [6:0] seg, input logic dp);
        chk({nm, "_AN"}, AN, an);
        chk({nm, "_SEG"}, {1'b0, SEG}, {1'b0, seg});
        chk({nm, "_DP"}, {7'b0, DP}, {7'b0, dp});
    endtask

    initial begin
        int k;
        int pulses;
        rst = 1'b1; W = 1'b0; WADD = '0; DIN = '0;
        skip(2);
        armed = 1'b1;
        chk_disp("reset", 8'hFF, 7'h7F, 1'b1);
        chk("reset_FRAME", {7'b0, FRAME}, 8'h00);
        rst = 1'b0;

        // 1: idle scan, first FRAME 64 cycles after release, then every 64
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (FRAME !== 1'b1 && k < 200);
        chk("first_frame_cycle", 8'(k), 8'd64);
        pulses = 0;
        for (int i = 0; i < 128; i++) begin
            @(negedge clk);
            if (FRAME === 1'b1) pulses++;
            if (AN !== 8'hFF) pulses = pulses + 100;
        end
        chk("idle_frame_pulses", 8'(pulses), 8'd2);

        // 2: write all digits with their own index
        for (int h = 7; h >= 0; h--) begin
            @(negedge clk);
            W = 1'b1; WADD = 3'(h); DIN = {1'b1, 4'(h), 1'b0};
        end
        @(negedge clk);
        W = 1'b0;
        wait_frame();
        skip(2);  chk("d7_blank", AN, 8'hFF);
        skip(1);  chk_disp("d7_show_first", 8'h7F, 7'h78, 1'b0);
        skip(5);  chk_disp("d7_show_last", 8'h7F, 7'h78, 1'b0);
        skip(1);  chk("d6_blank", AN, 8'hFF);
        skip(2);  chk_disp("d6_show", 8'hBF, 7'h02, 1'b0);

        // 3: mid-frame write is held until the next commit
        wait_frame();
        wr(3'd3, 6'b1_1010_1);
        skip(33); chk_disp("d3_before_commit", 8'hF7, 7'h30, 1'b0);
        wait_frame();
        skip(35); chk_disp("d3_after_commit", 8'hF7, 7'h08, 1'b1);

        // 4: write on the wrap edge appears one frame later
        wait_frame();
        skip(63);
        W = 1'b1; WADD = 3'd0; DIN = 6'b1_1111_0;
        skip(1);
        chk("wrap_write_frame", {7'b0, FRAME}, 8'h01);
        W = 1'b0;
        skip(59); chk_disp("d0_old", 8'hFE, 7'h40, 1'b0);
        wait_frame();
        skip(59); chk_disp("d0_new", 8'hFE, 7'h0E, 1'b0);

        // 5: disabled digit stays dark
        wr(3'd5, 6'b0_0101_0);
        wait_frame();
        skip(11); chk_disp("d6_still_lit", 8'hBF, 7'h02, 1'b0);
        skip(8);
        for (int i = 0; i < 6; i++) begin
            chk_disp("d5_dark", 8'hFF, 7'h7F, 1'b1);
            if (i < 5) skip(1);
        end

        // 6: reset during digit 2 SHOW
        wait_frame();
        skip(44); chk_disp("d2_show_pre_rst", 8'hFB, 7'h24, 1'b0);
        #1 rst = 1'b1;
        #1 chk_disp("rst_immediate", 8'hFF, 7'h7F, 1'b1);
        chk("rst_immediate_FRAME", {7'b0, FRAME}, 8'h00);
        skip(3);
        rst = 1'b0;
        skip(3);  chk("after_rst_d7_dark", AN, 8'hFF);
        wait_frame();
        skip(3);  chk("after_rst_frame_d7_dark", AN, 8'hFF);
        wr(3'd7, 6'b1_1001_1);
        wait_frame();
        skip(3);  chk_disp("d7_rewritten", 8'h7F, 7'h10, 1'b1);

        skip(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/display_scanner.md
# display_scanner

Downstream consumer of the display controller's digit-write stream. Holds an 8-entry × 6-bit digit memory written through the W/WADD/DIN port. Time-multiplexes the memory onto an 8-digit common-anode seven-segment display: one digit at a time, with inter-digit blanking and hex-to-segment decoding. Writes land in a shadow buffer, which is committed to the displayed buffer only at a frame boundary, so a partial 8-digit update never tears.

## Interface
- REFRESH_DIV, 100000: clk cycles per digit slot; legal range ≥ 2.
- BLANK_CYCLES, 2000: cycles at the start of each slot with all anodes off; must be < REFRESH_DIV.
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- W  input  1  write strobe, active-high; sampled on the clk rising edge.
- WADD  input  3  digit address to write, 0..7.
- DIN  input  6  digit word: [5] enable (1 = digit lit), [4:1] hex value, [0] decimal point (1 = dp dark, 0 = dp lit).
- AN  output  8  anode drives, active-low; AN[i] drives digit i.
- SEG  output  7  {g,f,e,d,c,b,a}, active-low.
- DP  output  1  decimal point, active-low.
- FRAME  output  1  one-cycle pulse on the cycle the scan wraps from digit 0 to digit 7.

## Operation
- Storage:
  - shadow[0..7] and active[0..7], each 6 bits.
  - One dirty flag.
  - Slot counter cnt, width $clog2(REFRESH_DIV).
  - Digit index idx, 3 bits.
- Write: when W = 1 on a rising edge, shadow[WADD] <= DIN and dirty <= 1. Writes are never dropped.
- Scan order is 7, 6, …, 0, then wrap to 7. Each digit occupies one slot of REFRESH_DIV cycles.
- cnt counts 0..REFRESH_DIV-1. At cnt = REFRESH_DIV-1, cnt <= 0 and idx <= idx-1, mod 8.
- State machine has two states per slot:
  - BLANK: entered when cnt = 0; held while cnt < BLANK_CYCLES.
  - SHOW: cnt ≥ BLANK_CYCLES.
  - BLANK to SHOW when cnt reaches BLANK_CYCLES. SHOW to BLANK at the slot end.
- Frame commit: on the edge where idx wraps 0 → 7, if dirty = 1 then active <= shadow (all 8 entries) and dirty <= 0. FRAME is asserted on that same edge whether or not dirty is set.
- Write coinciding with commit:
  - active takes the pre-write shadow contents.
  - The new write goes to shadow and dirty ends at 1 (set wins over clear).
  - The write appears one frame later.
- Output decode, all registered, using d = active[idx]:
  - In BLANK, or when d[5] = 0: AN = 8'hFF, SEG = 7'h7F, DP = 1.
  - In SHOW with d[5] = 1: AN = ~(8'b1 << idx), SEG = hex7(d[4:1]), DP = d[0].
- hex7 encoding ({g..a}):
  - 0=0x40, 1=0x79, 2=0x24, 3=0x30, 4=0x19, 5=0x12, 6=0x02, 7=0x78
  - 8=0x00, 9=0x10, A=0x08, b=0x03, C=0x46, d=0x21, E=0x06, F=0x0E
- At most one AN bit is low in any cycle.

## Timing
- Reset values (asynchronous, while rst = 1):
  - AN = 8'hFF, SEG = 7'h7F, DP = 1, FRAME = 0.
  - shadow = 0 and active = 0 (all digits disabled); dirty = 0.
  - cnt = 0, idx = 7, state = BLANK.
- After rst deasserts, the first slot is digit 7 and starts at cnt = 0.
- Output latency: outputs reflect the state/cnt/idx of the previous cycle (one register stage). AN goes low on the cycle after cnt first equals BLANK_CYCLES.
- Write-to-display latency: from the write edge to the next wrap edge, plus 1 cycle for output registration, plus BLANK_CYCLES. Worst case is 8·REFRESH_DIV + BLANK_CYCLES + 1.
- Full frame period is 8·REFRESH_DIV cycles. FRAME pulses exactly once per frame.
- Reset mid-frame: everything returns to reset values immediately, including the shadow contents and pending writes.
- W with WADD already written in the same frame: last write wins.

## Test plan
1. Reset only, REFRESH_DIV=8, BLANK_CYCLES=2 -> AN stays 8'hFF, SEG stays 7'h7F, DP stays 1 for 3 frames; FRAME pulses every 64 cycles.
2. Write all 8 digits {1,h,0} (h = digit index, i.e. DIN = {1'b1, h, 1'b0}) as 8 consecutive writes, WADD 7..0 -> after the next wrap, the digit-7 slot shows AN = 8'h7F and SEG = 0x78 for 6 cycles, then digit 6 shows AN = 8'hBF and SEG = 0x02; DP = 0 throughout SHOW.
3. Write WADD=3 with DIN=6'b1_1010_1 mid-frame -> displayed digit 3 does not change until after FRAME; afterwards the digit-3 slot shows SEG = 0x08, DP = 1.
4. Write coinciding with the wrap edge (WADD=0, DIN=6'b1_1111_0) -> the next frame shows the old digit 0; the frame after shows SEG = 0x0E and DP = 0; dirty clears only after the second commit.
5. Write DIN[5]=0 to digit 5 -> digit-5 slot keeps AN = 8'hFF and SEG = 7'h7F for its whole slot, while the other digits scan normally.
6. Assert rst during a SHOW phase of digit 2 -> on the same cycle AN = 8'hFF; after release, the scan restarts at digit 7 with all digits dark until new writes are committed.
